// File: rtl/swd_xfer_ctl.sv
// swd_xfer_ctl: transfer sequencer in front of the SWD bit engine.
// Takes one DP/AP command, launches it with go/idle, retries on WAIT,
// detects an engine that never starts, and returns one response per command.
// Optional value-match read loop: define SWD_VALUE_MATCH_EN.
module swd_xfer_ctl #(
  parameter int WAIT_RETRY     = 100,
  parameter int LAUNCH_TIMEOUT = 4096,
  parameter int MATCH_RETRY    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_apndp,
  input  logic        cmd_rnw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_match,
  input  logic [31:0] match_mask,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_ack,
  output logic        rsp_perr,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_waits,
  output logic        rsp_tmo,
  output logic        rsp_mismatch,
  output logic        swd_go,
  output logic [1:0]  swd_addr32,
  output logic        swd_rnw,
  output logic        swd_apndp,
  output logic [31:0] swd_dwrite,
  input  logic [2:0]  swd_ack,
  input  logic [31:0] swd_dread,
  input  logic        swd_perr,
  input  logic        swd_idle
);
  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [2:0] ACK_OK   = 3'b001;
  localparam logic [2:0] ACK_WAIT = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_EVAL, S_RESP} state_t;

  state_t         state;
  logic           apndp_q, rnw_q;
  logic [1:0]     addr_q;
  logic [31:0]    wdata_q;
  logic [TW-1:0]  timer;
  logic           mmiss;

`ifdef SWD_VALUE_MATCH_EN
  logic           match_q;
  logic [7:0]     mcnt;
  // a match-mode read whose masked value is not yet the one we wait for
  assign mmiss = rnw_q && match_q &&
                 ((swd_dread & match_mask) != (wdata_q & match_mask));
`else
  logic unused_match;
  assign unused_match = ^{cmd_match, match_mask};
  assign mmiss = 1'b0;
`endif

  // accept only when nothing is pending and the engine is quiet
  assign cmd_ready  = rst && (state == S_IDLE) && !rsp_valid && swd_idle;

  // engine sees the latched command for the whole transfer, retries included
  assign swd_addr32 = addr_q;
  assign swd_rnw    = rnw_q;
  assign swd_apndp  = apndp_q;
  assign swd_dwrite = wdata_q;

  // sequencer: launch, wait for engine, evaluate ACK, hold response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      apndp_q      <= 1'b0;
      rnw_q        <= 1'b0;
      addr_q       <= 2'd0;
      wdata_q      <= 32'd0;
      timer        <= '0;
      swd_go       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_ack      <= 3'd0;
      rsp_perr     <= 1'b0;
      rsp_data     <= 32'd0;
      rsp_waits    <= 8'd0;
      rsp_tmo      <= 1'b0;
      rsp_mismatch <= 1'b0;
`ifdef SWD_VALUE_MATCH_EN
      match_q      <= 1'b0;
      mcnt         <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          apndp_q      <= cmd_apndp;
          rnw_q        <= cmd_rnw;
          addr_q       <= cmd_addr;
          wdata_q      <= cmd_wdata;
`ifdef SWD_VALUE_MATCH_EN
          match_q      <= cmd_match;
`endif
          rsp_ack      <= 3'd0;
          rsp_perr     <= 1'b0;
          rsp_data     <= 32'd0;
          rsp_tmo      <= 1'b0;
          rsp_mismatch <= 1'b0;
          timer        <= '0;
          swd_go       <= 1'b1;
          state        <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (!swd_idle) begin
            swd_go <= 1'b0;
            timer  <= '0;
            state  <= S_BUSY;
          end else if (timer == TW'(LAUNCH_TIMEOUT - 1)) begin
            swd_go    <= 1'b0;
            rsp_tmo   <= 1'b1;
            rsp_ack   <= 3'd0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // the engine always finishes a transfer it has started
        S_BUSY: if (swd_idle) state <= S_EVAL;
        S_EVAL: begin
          if (swd_ack == ACK_WAIT && rsp_waits < 8'(WAIT_RETRY) && !abort) begin
            if (rsp_waits != 8'hFF) rsp_waits <= rsp_waits + 8'd1;
            swd_go <= 1'b1;
            timer  <= '0;
            state  <= S_LAUNCH;
`ifdef SWD_VALUE_MATCH_EN
          end else if (swd_ack == ACK_OK && !(rnw_q && swd_perr) && mmiss &&
                       mcnt < 8'(MATCH_RETRY) && !abort) begin
            if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
            swd_go <= 1'b1;
            timer  <= '0;
            state  <= S_LAUNCH;
`endif
          end else begin
            // every remaining outcome ends the command with a response
            rsp_ack   <= swd_ack;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
            if (swd_ack == ACK_OK) begin
              rsp_perr     <= rnw_q && swd_perr;
              rsp_data     <= rnw_q ? swd_dread : 32'd0;
              rsp_mismatch <= rnw_q && !swd_perr && mmiss;
            end
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_waits <= 8'd0;
          timer     <= '0;
`ifdef SWD_VALUE_MATCH_EN
          mcnt      <= 8'd0;
`endif
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
